rle_prefetch_fifo: RTL and testbench

//   Prefetch stage between the QSPI flash controller and the RLE video decoder.

---
 rtl/rle_prefetch_fifo_if.sv | 30 +++
 rtl/rle_prefetch_fifo.sv | 123 ++++++++++++
 tb/tb_rle_prefetch_fifo.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_prefetch_fifo_if.sv
// Request/response bus between the RLE prefetch stage and the QSPI flash controller.
interface rle_prefetch_fifo_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_BITS  = 24
);
   logic                  spi_start_read;
   logic                  spi_continue_read;
   logic                  spi_stop_read;
   logic [ADDR_BITS-1:0]  spi_addr;
   logic [DATA_WIDTH-1:0] spi_data;
   logic                  spi_busy;

   modport master (
      output spi_start_read,
      output spi_continue_read,
      output spi_stop_read,
      output spi_addr,
      input  spi_data,
      input  spi_busy
   );

   modport slave (
      input  spi_start_read,
      input  spi_continue_read,
      input  spi_stop_read,
      input  spi_addr,
      output spi_data,
      output spi_busy
   );
endinterface

// File: rtl/rle_prefetch_fifo.sv
// Keeps a small FWFT FIFO of RLE words topped up from flash, one request in flight at a time.
module rle_prefetch_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4,
   parameter int ADDR_BITS  = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_BITS-1:0]   start_addr,
   rle_prefetch_fifo_if.master    spi,
   input  logic                   read_next,
   input  logic                   stop_data,
   output logic                   data_ready,
   output logic [DATA_WIDTH-1:0]  data,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT1,
      S_WAIT,
      S_FILL
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic                  start_q;
   logic                  cont_q;
   logic                  stop_q;
   logic [ADDR_BITS-1:0]  addr_q;
   logic                  pending;
   logic                  flush;
   logic                  push;
   logic                  pop;
   logic [LW-1:0]         level_nxt;

   // stop_data outranks both push and pop in the same cycle
   always_comb begin
      flush     = stop_data && (state != S_IDLE);
      push      = (state == S_WAIT) && !spi.spi_busy && !stop_data;
      pop       = read_next && (level != '0) && (state != S_IDLE) && !stop_data;
      level_nxt = level + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= spi.spi_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         start_q <= 1'b0;
         cont_q  <= 1'b0;
         stop_q  <= 1'b0;
         addr_q  <= '0;
         pending <= 1'b0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level   <= '0;
         data    <= '0;
      end else begin
         start_q <= 1'b0;
         cont_q  <= 1'b0;
         stop_q  <= 1'b0;
         if (flush) begin
            stop_q  <= 1'b1;
            state   <= S_IDLE;
            pending <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            // Head register: a word pushed into an otherwise empty FIFO is the new head
            if (push && (level == LW'(pop)))
               data <= spi.spi_data;
            else if (level_nxt != '0)
               data <= mem[rd_ptr + AW'(pop)];

            case (state)
               S_IDLE: begin
                  if (stop_data) begin
                     pending <= 1'b0;
                  end else if (read_next || pending) begin
                     if (!spi.spi_busy) begin
                        start_q <= 1'b1;
                        addr_q  <= start_addr;
                        pending <= 1'b0;
                        state   <= S_START;
                     end else begin
                        pending <= 1'b1;
                     end
                  end
               end
               S_START: state <= S_WAIT1;
               S_WAIT1: state <= S_WAIT;
               S_WAIT:  if (!spi.spi_busy) state <= S_FILL;
               S_FILL: begin
                  if (level_nxt < FULL) begin
                     cont_q <= 1'b1;
                     state  <= S_START;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign spi.spi_start_read    = start_q;
   assign spi.spi_continue_read = cont_q;
   assign spi.spi_stop_read     = stop_q;
   assign spi.spi_addr          = addr_q;
   assign data_ready            = (level != '0);
endmodule

// File: tb/tb_rle_prefetch_fifo.sv
// Bench for rle_prefetch_fifo: reactive flash model plus a queue reference of the FIFO contents.
module tb_rle_prefetch_fifo;
   localparam int DW = 16;
   localparam int D  = 4;
   localparam int AB = 24;
   localparam int LW = $clog2(D) + 1;

   typedef struct {
      int            lat;
      logic [DW-1:0] base;
      logic [AB-1:0] addr;
      int            pop_pct;
      int            nwords;
      logic [DW-1:0] exp_first;
      logic [DW-1:0] exp_last;
   } vec_t;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic [AB-1:0] start_addr = '0;
   logic          read_next  = 1'b0;
   logic          stop_data  = 1'b0;
   logic          data_ready;
   logic [DW-1:0] data;
   logic [LW-1:0] level;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   rle_prefetch_fifo_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) spi ();

   rle_prefetch_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_BITS(AB)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_addr (start_addr),
      .spi        (spi),
      .read_next  (read_next),
      .stop_data  (stop_data),
      .data_ready (data_ready),
      .data       (data),
      .level      (level)
   );

   always #5 clk = ~clk;

   // Flash model: busy for lat cycles per request, returns base+k for the k-th word since a start.
   // A word whose request predates a stop_data is late and must never reach the FIFO.
   int            lat       = 6;
   logic [DW-1:0] base      = '0;
   logic          busy_m    = 1'b0;
   logic [DW-1:0] data_m    = '0;
   int            f_cnt     = 0;
   int            f_k       = 0;
   bit            f_fresh   = 1'b0;
   int            gen       = 0;
   int            f_req_gen = 0;
   int            n_req     = 0;
   int            n_done    = 0;
   int            full_viol = 0;
   logic [DW-1:0] refq[$];
   logic [DW-1:0] ref_data  = '0;
   int            ref_sz;

   assign spi.spi_busy = busy_m;
   assign spi.spi_data = data_m;

   always @(posedge clk) begin
      ref_sz = refq.size();
      f_fresh <= 1'b0;
      if (rst) begin
         busy_m    <= 1'b0;
         data_m    <= '0;
         f_cnt     <= 0;
         f_k       <= 0;
         gen       <= 0;
         f_req_gen <= 0;
         refq.delete();
         ref_data = '0;
      end else begin
         if (spi.spi_start_read || spi.spi_continue_read) begin
            busy_m    <= 1'b1;
            f_cnt     <= lat;
            f_req_gen <= gen;
            n_req     <= n_req + 1;
            if (spi.spi_start_read) f_k <= 0;
         end else if (busy_m) begin
            f_cnt <= f_cnt - 1;
            if (f_cnt == 1) begin
               busy_m  <= 1'b0;
               data_m  <= base + DW'(f_k);
               f_k     <= f_k + 1;
               f_fresh <= 1'b1;
               n_done  <= n_done + 1;
            end
         end
         if (stop_data) begin
            gen <= gen + 1;
            refq.delete();
         end else begin
            if (read_next && ref_sz > 0) void'(refq.pop_front());
            if (f_fresh && f_req_gen == gen) begin
               if (refq.size() >= D) full_viol++;
               refq.push_back(data_m);
            end
            if (refq.size() != 0) ref_data = refq[0];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle_checks();
      chk("level", 32'(level), 32'(refq.size()));
      chk("data_ready", 32'(data_ready), 32'(refq.size() != 0));
      chk("data", 32'(data), 32'(ref_data));
      chk("pulse_onehot", 32'($countones({spi.spi_start_read, spi.spi_continue_read,
                                          spi.spi_stop_read}) <= 1), 32'd1);
      if (spi.spi_start_read || spi.spi_continue_read)
         chk("req_while_busy", 32'(busy_m), 32'd0);
      chk("push_when_full", 32'(full_viol), 32'd0);
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk_on) cycle_checks();
      @(posedge clk);
      #1;
   endtask

   task automatic stop_pulse(input string tag);
      int w;
      stop_data = 1'b1;
      tick();
      stop_data = 1'b0;
      chk({tag, "_stop_pulse"}, 32'(spi.spi_stop_read), 32'd1);
      chk({tag, "_stop_level"}, 32'(level), 32'd0);
      chk({tag, "_stop_ready"}, 32'(data_ready), 32'd0);
      w = 0;
      while (busy_m && w < 60) begin tick(); w++; end
      tick();
      tick();
   endtask

   task automatic wait_start(input string tag);
      int w;
      w = 0;
      while (!spi.spi_start_read && w < 60) begin tick(); w++; end
      chk({tag, "_start_seen"}, 32'(spi.spi_start_read), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          vecs[4];
      int            req0;
      int            w;
      int            popped;
      logic [DW-1:0] first_w;
      logic [DW-1:0] last_w;

      vecs[0] = '{8,  16'h0001, 24'h000000, 100, 64, 16'h0001, 16'h0040};
      vecs[1] = '{3,  16'hA000, 24'h123456, 50,  40, 16'hA000, 16'hA027};
      vecs[2] = '{1,  16'hFFF0, 24'hFFFFFF, 30,  30, 16'hFFF0, 16'h000D};
      vecs[3] = '{12, 16'h0100, 24'h000010, 80,  20, 16'h0100, 16'h0113};
      first_w = '0;
      last_w  = '0;

      // reset held for two edges, then ten quiet cycles
      @(posedge clk);
      chk_on = 1'b1;
      #1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst_pulses", 32'({spi.spi_start_read, spi.spi_continue_read, spi.spi_stop_read}), 32'd0);
         chk("rst_addr", 32'(spi.spi_addr), 32'd0);
         chk("rst_ready", 32'(data_ready), 32'd0);
         chk("rst_data", 32'(data), 32'd0);
         chk("rst_level", 32'(level), 32'd0);
      end

      // first start, fill to four words with no pops
      lat = 6; base = 16'h1234; start_addr = 24'h000100;
      req0 = n_req;
      read_next = 1'b1;
      tick();
      read_next = 1'b0;
      wait_start("t2");
      chk("t2_addr", 32'(spi.spi_addr), 32'h000100);
      tick();
      chk("t2_start_one_cycle", 32'(spi.spi_start_read), 32'd0);
      w = 0;
      while (!data_ready && w < 30) begin tick(); w++; end
      chk("t2_first_ready", 32'(data_ready), 32'd1);
      chk("t2_first_data", 32'(data), 32'h1234);
      repeat (80) tick();
      chk("t2_req_count", 32'(n_req - req0), 32'd4);
      chk("t2_full_level", 32'(level), 32'd4);

      // pop down to two, then pop in the same cycle as the next push
      read_next = 1'b1;
      tick();
      tick();
      read_next = 1'b0;
      chk("t4_level_two", 32'(level), 32'd2);
      chk("t4_head_before", 32'(data), 32'h1236);
      w = 0;
      while (!f_fresh && w < 40) begin tick(); w++; end
      chk("t4_push_cycle_level", 32'(level), 32'd2);
      read_next = 1'b1;
      tick();
      read_next = 1'b0;
      chk("t4_level_after", 32'(level), 32'd2);
      chk("t4_head_after", 32'(data), 32'h1237);
      stop_pulse("t4");

      // stop at level three with a word in flight; restart while the late word is pending
      lat = 6; base = 16'h5000; start_addr = 24'h000100;
      read_next = 1'b1;
      tick();
      read_next = 1'b0;
      w = 0;
      while (!(level == 3 && busy_m) && w < 100) begin tick(); w++; end
      chk("t5_reached_l3_busy", 32'(level == 3 && busy_m), 32'd1);
      req0 = n_req;
      stop_pulse("t5");
      chk("t5_no_new_req", 32'(n_req - req0), 32'd0);
      start_addr = 24'h000200;
      req0 = n_req;
      read_next = 1'b1;
      tick();
      read_next = 1'b0;
      wait_start("t5");
      chk("t5_restart_addr", 32'(spi.spi_addr), 32'h000200);
      w = 0;
      while (!data_ready && w < 30) begin tick(); w++; end
      chk("t5_restart_data", 32'(data), 32'h5000);
      stop_pulse("t5b");

      // slow flash with the decoder always asking: never more than one request in flight
      lat = 12; base = 16'h6000; start_addr = 24'h000300;
      read_next = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("t6_one_outstanding", 32'((n_req - n_done) <= 1), 32'd1);
         chk("t6_level_low", 32'(level <= 1), 32'd1);
      end
      read_next = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_level", 32'(level), 32'd0);
      chk("t6_rst_ready", 32'(data_ready), 32'd0);
      chk("t6_rst_data", 32'(data), 32'd0);
      chk("t6_rst_addr", 32'(spi.spi_addr), 32'd0);
      repeat (3) tick();

      // randomized decoder pops over the vector table
      for (int i = 0; i < 4; i++) begin
         lat = vecs[i].lat; base = vecs[i].base; start_addr = vecs[i].addr;
         read_next = 1'b1;
         tick();
         read_next = 1'b0;
         wait_start($sformatf("v%0d", i));
         chk($sformatf("v%0d_addr", i), 32'(spi.spi_addr), 32'(vecs[i].addr));
         popped = 0;
         w = 0;
         while (popped < vecs[i].nwords && w < 4000) begin
            read_next = ($urandom_range(99) < vecs[i].pop_pct);
            if (read_next && data_ready) begin
               if (popped == 0) first_w = data;
               last_w = data;
               popped++;
            end
            tick();
            w++;
         end
         read_next = 1'b0;
         chk($sformatf("v%0d_count", i), 32'(popped), 32'(vecs[i].nwords));
         chk($sformatf("v%0d_first", i), 32'(first_w), 32'(vecs[i].exp_first));
         chk($sformatf("v%0d_last", i), 32'(last_w), 32'(vecs[i].exp_last));
         stop_pulse($sformatf("v%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
